// File: rtl/mips_io_pkg.sv
// Shared constants, types and sizing helper for the CPU system's board I/O conditioning blocks.
package mips_io_pkg;

   localparam int SW_WIDTH                = 8;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

   // What one debounce bit does on the coming edge.
   typedef enum logic [1:0] {
      ACT_CLEAR  = 2'd0,
      ACT_COUNT  = 2'd1,
      ACT_ACCEPT = 2'd2
   } debounceAction_t;

   // Width needed to hold values 0..maxValue, never less than one bit.
   function automatic int clog2_cnt(input int maxValue);
      int bits;
      bits = 1;
      while ((1 << bits) <= maxValue) begin
         bits++;
      end
      return bits;
   endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// One debounced switch bit: stability counter, accepted level and a one-cycle change pulse.
module switch_debounce_bit
   import mips_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = clog2_cnt(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic syncIn,
   output logic stable,
   output logic changed,
   output logic accept
);

   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] count;
   debounceAction_t  action;

   // Any agreement with the held level restarts the count, so bounces never accumulate.
   always_comb begin
      action = ACT_COUNT;
      if (syncIn == stable) begin
         action = ACT_CLEAR;
      end else if (count == LAST_COUNT) begin
         action = ACT_ACCEPT;
      end
   end

   assign accept = (action == ACT_ACCEPT);

   // Counter tops out at LAST_COUNT because reaching it with a mismatch always accepts.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         stable  <= 1'b0;
         changed <= 1'b0;
      end else begin
         changed <= 1'b0;
         unique case (action)
            ACT_CLEAR: begin
               count <= '0;
            end
            ACT_ACCEPT: begin
               stable  <= syncIn;
               count   <= '0;
               changed <= 1'b1;
            end
            default: begin
               count <= count + CNT_W'(1);
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Synchronises and debounces the board slide switches feeding the memory-mapped switch port.
// Defining SWDEB_STICKY_EN adds sticky_clr / sw_sticky, a latched record of accepted changes.
module switch_debouncer
   import mips_io_pkg::*;
#(
   parameter int WIDTH           = SW_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] switches,
   output logic [WIDTH-1:0] sw_changed
`ifdef SWDEB_STICKY_EN
   ,
   input  logic             sticky_clr,
   output logic [WIDTH-1:0] sw_sticky
`endif
);

   localparam int CNT_W = clog2_cnt(DEBOUNCE_CYCLES);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] acceptVec;

   // Plain two-flop synchroniser; nothing may sit between the stages.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : gBit
      switch_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) uBit (
         .clk     (clk),
         .reset   (reset),
         .syncIn  (sync2[i]),
         .stable  (switches[i]),
         .changed (sw_changed[i]),
         .accept  (acceptVec[i])
      );
   end

`ifdef SWDEB_STICKY_EN
   // A set arriving together with a clear wins so that no change event is ever lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sw_sticky <= '0;
      end else begin
         sw_sticky <= (sw_sticky & ~{WIDTH{sticky_clr}}) | acceptVec;
      end
   end
`else
   logic [WIDTH-1:0] unusedAccept;
   assign unusedAccept = acceptVec;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed self-checking bench for switch_debouncer (WIDTH=8, DEBOUNCE_CYCLES=4).
// Also covers the sticky record when built with SWDEB_STICKY_EN.
module tb_switch_debouncer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] sw_raw;
   logic [7:0] switches;
   logic [7:0] sw_changed;
`ifdef SWDEB_STICKY_EN
   logic       stickyClr;
   logic [7:0] sw_sticky;
`endif

   int testCount = 0;
   int failCount = 0;

   switch_debouncer #(
      .WIDTH           (8),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw_raw     (sw_raw),
      .switches   (switches),
      .sw_changed (sw_changed)
`ifdef SWDEB_STICKY_EN
      ,
      .sticky_clr (stickyClr),
      .sw_sticky  (sw_sticky)
`endif
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit so sampling is away from the edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] value);
      sw_raw = value;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   initial begin
      logic [7:0] bouncePattern [5];
      bouncePattern = '{8'h08, 8'h00, 8'h08, 8'h08, 8'h00};

      reset  = 1'b0;
      sw_raw = 8'hFF;
`ifdef SWDEB_STICKY_EN
      stickyClr = 1'b0;
`endif

      // Async reset between edges with all switches high.
      #12;
      reset = 1'b1;
      #1;
      checkOutput("rst_switches", switches, 8'h00);
      checkOutput("rst_changed", sw_changed, 8'h00);
`ifdef SWDEB_STICKY_EN
      checkOutput("rst_sticky", sw_sticky, 8'h00);
`endif

      applyStimulus(8'h00);
      tick(2);
      reset = 1'b0;
      tick(3);
      checkOutput("idle_switches", switches, 8'h00);

      // 00 -> A5 held from edge 0: accepted at edge 5.
      applyStimulus(8'hA5);
      for (int e = 0; e <= 4; e++) begin
         tick(1);
         checkOutput($sformatf("a5_hold_e%0d", e), switches, 8'h00);
         checkOutput($sformatf("a5_nochg_e%0d", e), sw_changed, 8'h00);
      end
      tick(1);
      checkOutput("a5_accept_sw", switches, 8'hA5);
      checkOutput("a5_accept_chg", sw_changed, 8'hA5);
      tick(1);
      checkOutput("a5_after_sw", switches, 8'hA5);
      checkOutput("a5_after_chg", sw_changed, 8'h00);

      // Return to 00: falling levels are accepted with the same latency.
      applyStimulus(8'h00);
      tick(5);
      checkOutput("fall_hold_sw", switches, 8'hA5);
      tick(1);
      checkOutput("fall_accept_sw", switches, 8'h00);
      checkOutput("fall_accept_chg", sw_changed, 8'hA5);
      tick(1);
      checkOutput("fall_after_chg", sw_changed, 8'h00);

      // Bit0 glitch of three cycles must never be accepted.
      applyStimulus(8'h01);
      tick(3);
      applyStimulus(8'h00);
      for (int e = 3; e <= 8; e++) begin
         tick(1);
         checkOutput($sformatf("glitch_sw_e%0d", e), switches, 8'h00);
         checkOutput($sformatf("glitch_chg_e%0d", e), sw_changed, 8'h00);
      end

      // Bit3 bounce 1,0,1,1,0 then held high from edge 5: single pulse at edge 10.
      for (int e = 0; e < 5; e++) begin
         applyStimulus(bouncePattern[e]);
         tick(1);
         checkOutput($sformatf("bounce_chg_e%0d", e), sw_changed, 8'h00);
      end
      applyStimulus(8'h08);
      for (int e = 5; e <= 9; e++) begin
         tick(1);
         checkOutput($sformatf("bounce_sw_e%0d", e), switches, 8'h00);
         checkOutput($sformatf("bounce_chg_e%0d", e), sw_changed, 8'h00);
      end
      tick(1);
      checkOutput("bounce_accept_sw", switches, 8'h08);
      checkOutput("bounce_accept_chg", sw_changed, 8'h08);
      tick(1);
      checkOutput("bounce_after_chg", sw_changed, 8'h00);

      // Bit7 mid-count (cnt=2 after edge 3), then a one-cycle reset pulse.
      applyStimulus(8'h88);
      tick(4);
      checkOutput("midcnt_sw", switches, 8'h08);
      reset = 1'b1;
      #1;
      checkOutput("midrst_sw", switches, 8'h00);
      checkOutput("midrst_chg", sw_changed, 8'h00);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int e = 0; e <= 4; e++) begin
         tick(1);
         checkOutput($sformatf("reacq_sw_e%0d", e), switches, 8'h00);
         checkOutput($sformatf("reacq_chg_e%0d", e), sw_changed, 8'h00);
      end
      tick(1);
      checkOutput("reacq_accept_sw", switches, 8'h88);
      checkOutput("reacq_accept_chg", sw_changed, 8'h88);
      tick(1);
      checkOutput("reacq_after_chg", sw_changed, 8'h00);

`ifdef SWDEB_STICKY_EN
      // Sticky: accept and clear on the same edge keeps the new event.
      checkOutput("sticky_pre", sw_sticky, 8'h88);
      applyStimulus(8'h8A);
      tick(5);
      checkOutput("sticky_pre_accept", sw_sticky, 8'h88);
      stickyClr = 1'b1;
      tick(1);
      stickyClr = 1'b0;
      checkOutput("sticky_coincide", sw_sticky, 8'h02);
      checkOutput("sticky_coincide_sw", switches, 8'h8A);
      tick(1);
      checkOutput("sticky_hold", sw_sticky, 8'h02);
      stickyClr = 1'b1;
      tick(1);
      stickyClr = 1'b0;
      checkOutput("sticky_cleared", sw_sticky, 8'h00);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
